// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage.
// Contents: exception cause codes and their priority rank, interrupt cause
// mapping, result-select encodings and the commit FSM state type.
package wb_pkg;

  // Interrupt cause codes for the first two lines; later lines map to 16+i-2.
  localparam int unsigned IrqCode0    = 7;
  localparam int unsigned IrqCode1    = 11;
  localparam int unsigned IrqCodeBase = 16;

  // Rank value meaning "this exception bit does not participate".
  localparam logic [3:0] ExcRankNone = 4'd15;

  typedef enum logic [1:0] {
    ResAlu = 2'd0,
    ResMem = 2'd1,
    ResNpc = 2'd2,
    ResCsr = 2'd3
  } res_sel_e;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } wb_state_e;

  // Priority rank of an exception cause (0 = highest). Order:
  // 3, 1, 2, 0, 11, 8, 9, 6, 4, 7, 5, 15, 13. All other causes are ignored.
  function automatic logic [3:0] exc_rank(input int unsigned cause);
    case (cause)
      3:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      0:       return 4'd3;
      11:      return 4'd4;
      8:       return 4'd5;
      9:       return 4'd6;
      6:       return 4'd7;
      4:       return 4'd8;
      7:       return 4'd9;
      5:       return 4'd10;
      15:      return 4'd11;
      13:      return 4'd12;
      default: return ExcRankNone;
    endcase
  endfunction

  // Cause code reported for interrupt line idx.
  function automatic logic [4:0] irq_code(input int unsigned idx);
    if (idx == 0) return 5'(IrqCode0);
    if (idx == 1) return 5'(IrqCode1);
    return 5'(IrqCodeBase + idx - 2);
  endfunction

endpackage

// File: rtl/wb_trap_arb.sv
// Combinational trap arbiter: picks the highest-priority synchronous exception,
// otherwise the highest-index enabled interrupt.
// Ports:
//   exc        16-bit exception flags, bit index = cause code
//   irq        level interrupt requests
//   mie_global global interrupt enable
//   mie_mask   per-line interrupt enables
//   take       a trap must be taken
//   is_int     the chosen trap is an interrupt
//   code       cause code of the chosen trap
module wb_trap_arb
  import wb_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 2
) (
  input  logic [15:0]        exc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mie_global,
  input  logic [NUM_IRQ-1:0] mie_mask,
  output logic               take,
  output logic               is_int,
  output logic [4:0]         code
);

  logic [NUM_IRQ-1:0] pending;
  logic [3:0]         best_rank;
  logic [4:0]         exc_code;
  logic               exc_hit;
  logic               irq_hit;
  logic [4:0]         irq_sel_code;

  always_comb begin
    best_rank = ExcRankNone;
    exc_code  = '0;
    for (int b = 0; b < 16; b++) begin
      if (exc[b] && (exc_rank(b) < best_rank)) begin
        best_rank = exc_rank(b);
        exc_code  = 5'(b);
      end
    end
    exc_hit = (best_rank != ExcRankNone);
  end

  always_comb begin
    pending      = irq & mie_mask & {NUM_IRQ{mie_global}};
    irq_hit      = 1'b0;
    irq_sel_code = '0;
    // Ascending scan with overwrite: the highest pending index wins.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i]) begin
        irq_hit      = 1'b1;
        irq_sel_code = irq_code(i);
      end
    end
  end

  always_comb begin
    take   = exc_hit | irq_hit;
    is_int = ~exc_hit & irq_hit;
    code   = exc_hit ? exc_code : irq_sel_code;
  end

endmodule

// File: rtl/wb_trap_commit.sv
// Writeback/commit stage: registers the register-file write, takes traps
// (sync exceptions and interrupts) and MRET, drives PC redirects and holds a
// flush window of FLUSH_CYCLES cycles after every redirect. Counts retirements.
// Ports:
//   clk, reset                     clock, async active-low reset
//   wb_v, wb_pc, wb_npc            valid instruction, its PC and PC+4
//   wb_alu/mem_result, wb_csr_rdata, wb_res_sel   result candidates and select
//   wb_drid, wb_rd_we              destination register and write enable
//   wb_exc, wb_tval, wb_mret       exception flags, trap value, MRET marker
//   irq, mie_global, mie_mask      interrupt requests and enables
//   mtvec, mepc_in                 CSR values for trap entry and MRET
//   wb_st_reg, wb_drid_out, wb_rf_data          registered RF write
//   trap_st, trap_epc/tval/cause   trap CSR update pulse and values
//   mret_st                        MRET status-restore pulse
//   wb_pc_mux_out, wb_br_jmp_target redirect pulse and target
//   flush                          kill IF..MEM
//   retire, retire_cnt             commit pulse and retired-instruction count
module wb_trap_commit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NUM_IRQ      = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_v,
  input  logic [XLEN-1:0]    wb_pc,
  input  logic [XLEN-1:0]    wb_npc,
  input  logic [XLEN-1:0]    wb_alu_result,
  input  logic [XLEN-1:0]    wb_mem_result,
  input  logic [XLEN-1:0]    wb_csr_rdata,
  input  logic [1:0]         wb_res_sel,
  input  logic [4:0]         wb_drid,
  input  logic               wb_rd_we,
  input  logic [15:0]        wb_exc,
  input  logic [XLEN-1:0]    wb_tval,
  input  logic               wb_mret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mie_global,
  input  logic [NUM_IRQ-1:0] mie_mask,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_in,
  output logic               wb_st_reg,
  output logic [4:0]         wb_drid_out,
  output logic [XLEN-1:0]    wb_rf_data,
  output logic               trap_st,
  output logic [XLEN-1:0]    trap_epc,
  output logic [XLEN-1:0]    trap_tval,
  output logic [XLEN-1:0]    trap_cause,
  output logic               mret_st,
  output logic               wb_pc_mux_out,
  output logic [XLEN-1:0]    wb_br_jmp_target,
  output logic               flush,
  output logic               retire,
  output logic [XLEN-1:0]    retire_cnt
);

  // Flush counter holds the number of flush cycles still to go after the first.
  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  wb_state_e       state_q;
  logic [CntW-1:0] flush_cnt_q;

  logic            arb_take;
  logic            arb_is_int;
  logic [4:0]      arb_code;
  logic [XLEN-1:0] rf_sel;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] cause_val;

  wb_trap_arb #(
    .NUM_IRQ (NUM_IRQ)
  ) u_arb (
    .exc        (wb_exc),
    .irq        (irq),
    .mie_global (mie_global),
    .mie_mask   (mie_mask),
    .take       (arb_take),
    .is_int     (arb_is_int),
    .code       (arb_code)
  );

  always_comb begin
    rf_sel = wb_alu_result;
    unique case (res_sel_e'(wb_res_sel))
      ResAlu: rf_sel = wb_alu_result;
      ResMem: rf_sel = wb_mem_result;
      ResNpc: rf_sel = wb_npc;
      ResCsr: rf_sel = wb_csr_rdata;
    endcase
  end

  always_comb begin
    trap_base = {mtvec[XLEN-1:2], 2'b00};
    // Vectored mode only applies to interrupts; exceptions always go to the base.
    if (arb_is_int && (mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + (XLEN'(arb_code) << 2);
    end else begin
      trap_target = trap_base;
    end
    cause_val = {arb_is_int, {(XLEN-6){1'b0}}, arb_code};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StRun;
      flush_cnt_q      <= '0;
      wb_st_reg        <= 1'b0;
      wb_drid_out      <= '0;
      wb_rf_data       <= '0;
      trap_st          <= 1'b0;
      trap_epc         <= '0;
      trap_tval        <= '0;
      trap_cause       <= '0;
      mret_st          <= 1'b0;
      wb_pc_mux_out    <= 1'b0;
      wb_br_jmp_target <= '0;
      flush            <= 1'b0;
      retire           <= 1'b0;
      retire_cnt       <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      wb_st_reg     <= 1'b0;
      trap_st       <= 1'b0;
      mret_st       <= 1'b0;
      wb_pc_mux_out <= 1'b0;
      retire        <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (wb_v) begin
            if (arb_take) begin
              trap_st          <= 1'b1;
              trap_epc         <= wb_pc;
              trap_tval        <= arb_is_int ? '0 : wb_tval;
              trap_cause       <= cause_val;
              wb_br_jmp_target <= trap_target;
              wb_pc_mux_out    <= 1'b1;
              flush            <= 1'b1;
              flush_cnt_q      <= CntW'(FLUSH_CYCLES - 1);
              state_q          <= StFlush;
            end else if (wb_mret) begin
              mret_st          <= 1'b1;
              retire           <= 1'b1;
              retire_cnt       <= retire_cnt + 1'b1;
              wb_br_jmp_target <= mepc_in;
              wb_pc_mux_out    <= 1'b1;
              flush            <= 1'b1;
              flush_cnt_q      <= CntW'(FLUSH_CYCLES - 1);
              state_q          <= StFlush;
            end else begin
              wb_st_reg   <= wb_rd_we && (wb_drid != 5'd0);
              wb_drid_out <= wb_drid;
              wb_rf_data  <= rf_sel;
              retire      <= 1'b1;
              retire_cnt  <= retire_cnt + 1'b1;
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            flush   <= 1'b0;
            state_q <= StRun;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trap_commit.sv
module tb_wb_trap_commit;

  localparam int unsigned XLEN         = 64;
  localparam int unsigned NUM_IRQ      = 2;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               wb_v;
  logic [XLEN-1:0]    wb_pc, wb_npc, wb_alu_result, wb_mem_result, wb_csr_rdata;
  logic [1:0]         wb_res_sel;
  logic [4:0]         wb_drid;
  logic               wb_rd_we;
  logic [15:0]        wb_exc;
  logic [XLEN-1:0]    wb_tval;
  logic               wb_mret;
  logic [NUM_IRQ-1:0] irq;
  logic               mie_global;
  logic [NUM_IRQ-1:0] mie_mask;
  logic [XLEN-1:0]    mtvec, mepc_in;
  logic               wb_st_reg;
  logic [4:0]         wb_drid_out;
  logic [XLEN-1:0]    wb_rf_data;
  logic               trap_st;
  logic [XLEN-1:0]    trap_epc, trap_tval, trap_cause;
  logic               mret_st;
  logic               wb_pc_mux_out;
  logic [XLEN-1:0]    wb_br_jmp_target;
  logic               flush;
  logic               retire;
  logic [XLEN-1:0]    retire_cnt;

  always #5 clk = ~clk;

  wb_trap_commit #(
    .XLEN         (XLEN),
    .NUM_IRQ      (NUM_IRQ),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_v             (wb_v),
    .wb_pc            (wb_pc),
    .wb_npc           (wb_npc),
    .wb_alu_result    (wb_alu_result),
    .wb_mem_result    (wb_mem_result),
    .wb_csr_rdata     (wb_csr_rdata),
    .wb_res_sel       (wb_res_sel),
    .wb_drid          (wb_drid),
    .wb_rd_we         (wb_rd_we),
    .wb_exc           (wb_exc),
    .wb_tval          (wb_tval),
    .wb_mret          (wb_mret),
    .irq              (irq),
    .mie_global       (mie_global),
    .mie_mask         (mie_mask),
    .mtvec            (mtvec),
    .mepc_in          (mepc_in),
    .wb_st_reg        (wb_st_reg),
    .wb_drid_out      (wb_drid_out),
    .wb_rf_data       (wb_rf_data),
    .trap_st          (trap_st),
    .trap_epc         (trap_epc),
    .trap_tval        (trap_tval),
    .trap_cause       (trap_cause),
    .mret_st          (mret_st),
    .wb_pc_mux_out    (wb_pc_mux_out),
    .wb_br_jmp_target (wb_br_jmp_target),
    .flush            (flush),
    .retire           (retire),
    .retire_cnt       (retire_cnt)
  );

  typedef struct {
    logic            st_reg;
    logic [4:0]      drid;
    logic [XLEN-1:0] rf_data;
    logic            trap_st;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] cause;
    logic            mret_st;
    logic            pc_mux;
    logic [XLEN-1:0] target;
    logic            flush;
    logic            retire;
    logic [XLEN-1:0] cnt;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            m_e;
  logic [XLEN-1:0] m_cnt;
  bit              m_in_flush;
  int              m_left;
  int              n_vec = 0;
  int              n_err = 0;
  int              exc_order[13] = '{3, 1, 2, 0, 11, 8, 9, 6, 4, 7, 5, 15, 13};

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check_val("wb_st_reg", XLEN'(wb_st_reg), XLEN'(e.st_reg));
    check_val("wb_drid_out", XLEN'(wb_drid_out), XLEN'(e.drid));
    check_val("wb_rf_data", wb_rf_data, e.rf_data);
    check_val("trap_st", XLEN'(trap_st), XLEN'(e.trap_st));
    check_val("trap_epc", trap_epc, e.epc);
    check_val("trap_tval", trap_tval, e.tval);
    check_val("trap_cause", trap_cause, e.cause);
    check_val("mret_st", XLEN'(mret_st), XLEN'(e.mret_st));
    check_val("pc_mux", XLEN'(wb_pc_mux_out), XLEN'(e.pc_mux));
    check_val("target", wb_br_jmp_target, e.target);
    check_val("flush", XLEN'(flush), XLEN'(e.flush));
    check_val("retire", XLEN'(retire), XLEN'(e.retire));
    check_val("retire_cnt", retire_cnt, e.cnt);
  endtask

  task automatic model_reset();
    m_e.st_reg  = 1'b0; m_e.drid = '0;   m_e.rf_data = '0; m_e.trap_st = 1'b0;
    m_e.epc     = '0;   m_e.tval = '0;   m_e.cause   = '0; m_e.mret_st = 1'b0;
    m_e.pc_mux  = 1'b0; m_e.target = '0; m_e.flush   = 1'b0; m_e.retire = 1'b0;
    m_e.cnt     = '0;
    m_cnt       = '0;
    m_in_flush  = 1'b0;
    m_left      = 0;
  endtask

  // Reference behaviour for one clock edge given the current inputs.
  task automatic model_step(output exp_t n);
    int  ec;
    int  ic;
    int  code;
    bit  is_int;
    n         = m_e;
    n.st_reg  = 1'b0;
    n.trap_st = 1'b0;
    n.mret_st = 1'b0;
    n.pc_mux  = 1'b0;
    n.retire  = 1'b0;
    ec = -1;
    ic = -1;
    if (m_in_flush) begin
      if (m_left > 0) m_left--;
      else begin
        n.flush    = 1'b0;
        m_in_flush = 1'b0;
      end
    end else if (wb_v) begin
      for (int k = 0; k < 13; k++) if (ec < 0 && wb_exc[exc_order[k]]) ec = exc_order[k];
      if (mie_global) begin
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
          if (ic < 0 && irq[k] && mie_mask[k]) ic = (k == 0) ? 7 : (k == 1) ? 11 : 14 + k;
        end
      end
      if (ec >= 0 || ic >= 0) begin
        is_int    = (ec < 0);
        code      = is_int ? ic : ec;
        n.trap_st = 1'b1;
        n.epc     = wb_pc;
        n.tval    = is_int ? '0 : wb_tval;
        n.cause   = (is_int ? {1'b1, {(XLEN-1){1'b0}}} : '0) | XLEN'(code);
        n.target  = (is_int && mtvec[1:0] == 2'b01) ? (mtvec & ~XLEN'(3)) + XLEN'(4 * code)
                                                      : (mtvec & ~XLEN'(3));
        n.pc_mux  = 1'b1;
        n.flush   = 1'b1;
        m_in_flush = 1'b1;
        m_left     = FLUSH_CYCLES - 1;
      end else if (wb_mret) begin
        n.mret_st  = 1'b1;
        n.target   = mepc_in;
        n.retire   = 1'b1;
        m_cnt      = m_cnt + 1;
        n.pc_mux   = 1'b1;
        n.flush    = 1'b1;
        m_in_flush = 1'b1;
        m_left     = FLUSH_CYCLES - 1;
      end else begin
        n.st_reg  = wb_rd_we && (wb_drid != 0);
        n.drid    = wb_drid;
        case (wb_res_sel)
          2'd0:    n.rf_data = wb_alu_result;
          2'd1:    n.rf_data = wb_mem_result;
          2'd2:    n.rf_data = wb_npc;
          default: n.rf_data = wb_csr_rdata;
        endcase
        n.retire = 1'b1;
        m_cnt    = m_cnt + 1;
      end
    end
    n.cnt = m_cnt;
    m_e   = n;
  endtask

  task automatic clear_in();
    wb_v = 1'b0; wb_pc = '0; wb_npc = '0; wb_alu_result = '0; wb_mem_result = '0;
    wb_csr_rdata = '0; wb_res_sel = '0; wb_drid = '0; wb_rd_we = 1'b0; wb_exc = '0;
    wb_tval = '0; wb_mret = 1'b0; irq = '0; mie_global = 1'b0; mie_mask = '0;
    mtvec = '0; mepc_in = '0;
  endtask

  // Called at a negedge with inputs set: push expectation, check after the edge.
  task automatic go();
    exp_t e;
    exp_t got;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", XLEN'(0), XLEN'(1));
    end else begin
      got = sb_q.pop_front();
      compare_out(got);
    end
    @(negedge clk);
    clear_in();
  endtask

  task automatic instr(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [XLEN-1:0] val);
    wb_v = 1'b1; wb_pc = 64'h1000; wb_npc = 64'h1004; wb_res_sel = sel;
    wb_drid = rd; wb_rd_we = we;
    wb_alu_result = val; wb_mem_result = val ^ 64'hA5; wb_csr_rdata = val + 64'h77;
  endtask

  // Present valid instructions during the flush window; none may commit.
  task automatic flush_window();
    for (int k = 0; k < FLUSH_CYCLES; k++) begin
      instr(2'd0, 5'd9, 1'b1, 64'h55);
      wb_mret = 1'b1; irq = '1; mie_global = 1'b1; mie_mask = '1;
      go();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z;
    clear_in();
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    z = m_e;
    compare_out(z);
    reset = 1'b1;
    @(negedge clk);

    // Normal commits: ADDI x1 = 5, then x0, then other result selects.
    instr(2'd0, 5'd1, 1'b1, 64'd5);  go();
    instr(2'd0, 5'd0, 1'b1, 64'd5);  go();
    instr(2'd1, 5'd7, 1'b1, 64'h30); go();
    instr(2'd2, 5'd8, 1'b1, 64'h31); go();
    instr(2'd3, 5'd9, 1'b0, 64'h32); go();

    // Idle: interrupt pending but no valid instruction.
    irq = 2'b10; mie_global = 1'b1; mie_mask = 2'b11; go();

    // Exceptions 4 and 1 -> cause 1.
    instr(2'd0, 5'd3, 1'b1, 64'h9);
    wb_pc = 64'h100; wb_exc = 16'h0012; wb_tval = 64'hDEAD; mtvec = 64'h800;
    go();
    flush_window();
    go();

    // IRQ[1] with vectored mtvec -> 0x82C.
    instr(2'd0, 5'd4, 1'b1, 64'h1);
    irq = 2'b10; mie_global = 1'b1; mie_mask = 2'b11; mtvec = 64'h801;
    go();
    flush_window();

    // Same with global enable off -> commit.
    instr(2'd0, 5'd4, 1'b1, 64'h2);
    irq = 2'b10; mie_global = 1'b0; mie_mask = 2'b11; mtvec = 64'h801;
    go();

    // IRQ[0] vectored -> 0x81C.
    instr(2'd0, 5'd4, 1'b1, 64'h3);
    irq = 2'b01; mie_global = 1'b1; mie_mask = 2'b11; mtvec = 64'h801;
    go();
    flush_window();

    // MRET, then MRET with exception 2.
    instr(2'd0, 5'd0, 1'b0, 64'h0); wb_mret = 1'b1; mepc_in = 64'h204; go();
    flush_window();
    instr(2'd0, 5'd0, 1'b0, 64'h0); wb_mret = 1'b1; mepc_in = 64'h204;
    wb_exc = 16'h0004; mtvec = 64'h900; go();
    flush_window();

    // Exception with both IRQs pending; IRQ taken after the flush window.
    instr(2'd0, 5'd5, 1'b1, 64'h4);
    wb_exc = 16'hA000; irq = 2'b11; mie_global = 1'b1; mie_mask = 2'b11; mtvec = 64'h801;
    go();
    flush_window();
    instr(2'd0, 5'd5, 1'b1, 64'h4);
    irq = 2'b11; mie_global = 1'b1; mie_mask = 2'b11; mtvec = 64'h801;
    go();
    flush_window();

    // Random exception patterns through the priority order.
    for (int r = 0; r < 8; r++) begin
      instr(2'd0, 5'd6, 1'b1, 64'(r));
      wb_exc = 16'($urandom); wb_pc = 64'h2000 + 64'(r * 4); wb_tval = 64'($urandom);
      mtvec = 64'h4000;
      go();
      flush_window();
    end

    // Reset in the middle of a flush window clears outputs immediately.
    instr(2'd0, 5'd1, 1'b1, 64'h1);
    wb_exc = 16'h0008; wb_pc = 64'h300; mtvec = 64'h800;
    go();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    sb_q.delete();
    z = m_e;
    compare_out(z);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Counter wrap from all-ones.
    force dut.retire_cnt = '1;
    #1;
    release dut.retire_cnt;
    m_cnt   = '1;
    m_e.cnt = '1;
    instr(2'd0, 5'd2, 1'b1, 64'h11); go();
    instr(2'd0, 5'd2, 1'b1, 64'h12); go();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_trap_commit.md
# wb_trap_commit

Parametrised writeback/commit stage for the RISC-V pipeline: selects and registers the register-file write, arbitrates synchronous exceptions and a configurable number of interrupt lines, and emits trap CSR updates and PC redirects. A small state machine holds a flush window after every trap or MRET. A retired-instruction counter is included. Sits between the MEM/WB pipeline register and the register file, CSR file and fetch PC mux.

## Interface
- XLEN, 64, datapath width
- NUM_IRQ, 2, interrupt lines (1..16)
- FLUSH_CYCLES, 2, cycles FLUSH is held after a redirect (>=1)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- WB_V  in  1  valid instruction in WB
- WB_PC, WB_NPC  in  XLEN  instruction PC, PC+4
- WB_ALU_RESULT, WB_MEM_RESULT, WB_CSR_RDATA  in  XLEN  result candidates
- WB_RES_SEL  in  2  0 ALU, 1 MEM, 2 NPC, 3 CSR
- WB_DRID  in  5  destination register; WB_RD_WE  in  1  write enable
- WB_EXC  in  16  synchronous exception flags, bit = cause code
- WB_TVAL  in  XLEN  faulting address or instruction
- WB_MRET  in  1  instruction is MRET
- IRQ  in  NUM_IRQ  level interrupt requests
- MIE_GLOBAL  in  1; MIE_MASK  in  NUM_IRQ  enables
- MTVEC, MEPC_IN  in  XLEN  CSR values
- WB_ST_REG  out  1; WB_DRID_OUT  out  5; WB_RF_DATA  out  XLEN  RF write
- TRAP_ST  out  1  pulse: write mepc/mcause/mtval
- TRAP_EPC, TRAP_TVAL, TRAP_CAUSE  out  XLEN  (CAUSE[XLEN-1] = interrupt)
- MRET_ST  out  1  pulse: restore status
- WB_PC_MUX_OUT  out  1; WB_BR_JMP_TARGET  out  XLEN  redirect
- FLUSH  out  1  kill IF..MEM
- RETIRE  out  1; RETIRE_CNT  out  XLEN  commit pulse, counter

## Operation
- States: RUN, FLUSH. Reset -> RUN.
- RUN, WB_V=1, decision priority: sync exception > interrupt > MRET > normal commit.
- Sync exception: any WB_EXC bit set. Cause is the first set bit in fixed order 3,1,2,0,11,8,9,6,4,7,5,15,13. Other bits are ignored. EPC=WB_PC, TVAL=WB_TVAL. No RF write.
- Interrupt: pending = IRQ & MIE_MASK, gated by MIE_GLOBAL. Highest index wins. Cause code: IRQ[0]=7, IRQ[1]=11, IRQ[i>=2]=16+i-2. EPC=WB_PC (instruction not committed). TVAL=0.
- Trap target: MTVEC[1:0]==1 and interrupt -> {MTVEC[XLEN-1:2],2'b0}+4*code; otherwise the base only.
- MRET: MRET_ST=1, target=MEPC_IN, no RF write; counts as retired.
- Normal commit: WB_ST_REG = WB_RD_WE & (WB_DRID!=0). RF data per WB_RES_SEL. RETIRE=1; RETIRE_CNT+1 (wraps modulo 2^XLEN).
- Trap, interrupt or MRET: WB_PC_MUX_OUT=1, then enter FLUSH.
- FLUSH: FLUSH=1 for FLUSH_CYCLES cycles. WB_V, IRQ and WB_MRET are ignored; nothing commits. Then return to RUN.
- WB_V=0 in RUN: no action; interrupts stay pending (level).

## Timing
- All outputs registered: decision in cycle N, outputs valid in cycle N+1.
- TRAP_ST, MRET_ST, RETIRE, WB_ST_REG and WB_PC_MUX_OUT are single-cycle pulses.
- FLUSH asserts in the same cycle as WB_PC_MUX_OUT and stays high for exactly FLUSH_CYCLES cycles.
- Reset: all outputs 0, RETIRE_CNT=0, state RUN. Reset during FLUSH aborts to RUN with FLUSH=0 immediately (asynchronous).
- Simultaneous exception and MRET: exception wins, MRET_ST stays 0.
- Exception and IRQ together: exception is taken; IRQ is taken on the next valid instruction after FLUSH, if still pending.

## Structure
- Package wb_pkg: cause-code constants, exception priority order, WB_RES_SEL encodings, state enum.
- Sub-module wb_trap_arb: combinational priority arbiter (exceptions + IRQ) producing take/cause/is_int. Unit-testable alone.

## Test plan
- ADDI x1 result 5 (WB_RES_SEL=0, WB_DRID=1, WB_V=1) -> next cycle WB_ST_REG=1, WB_RF_DATA=5, RETIRE=1, RETIRE_CNT=1. Same with WB_DRID=0 -> WB_ST_REG=0, RETIRE=1.
- WB_EXC bits 4 and 1 set, WB_PC=0x100, MTVEC=0x800 -> cause 1, TRAP_EPC=0x100, target 0x800, FLUSH high 2 cycles, no RF write.
- IRQ[1]=1, MIE set, MTVEC=0x801 -> TRAP_CAUSE=2^63|11, target 0x82C. Repeat with MIE_GLOBAL=0 -> normal commit.
- WB_MRET with MEPC_IN=0x204 -> MRET_ST=1, target 0x204. Repeat with WB_EXC[2] also set -> trap, MRET_ST=0.
- Valid instructions presented during FLUSH -> no commit, RETIRE_CNT unchanged. Reset asserted mid-FLUSH -> all outputs 0 at once.
- Preload RETIRE_CNT near all-ones (force), commit twice -> wraps to 0 then 1.
